// File: rtl/sample_packer.sv
// sample_packer: decimates probe lines, packs 16 samples per channel and emits channel-interleaved words
//
// Optional build macro: PACKER_TEST_PATTERN_EN. When it is defined, an internal counter replaces
// probe as the capture source, which makes the output fully deterministic.
//
// Ports:
//   clk                fast sample clock
//   rst_n              asynchronous active-low reset
//   probe              probe levels, already registered into the clk domain
//   acq_enable         acquisition run level
//   clock_divisor      a sample strobe fires every clock_divisor+1 cycles
//   channel_enable     per-channel enable mask, latched when a run starts
//   fifo_overflow      FIFO write-side overflow flag
//   sample_data        packed word driven to the FIFO din
//   sample_data_avail  FIFO write enable, one word per asserted cycle
//   stalled            sticky overflow indication, cleared only by returning to idle
module sample_packer #(
    parameter int NCH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] probe,
    input  logic           acq_enable,
    input  logic [7:0]     clock_divisor,
    input  logic [NCH-1:0] channel_enable,
    input  logic           fifo_overflow,
    output logic [NCH-1:0] sample_data,
    output logic           sample_data_avail,
    output logic           stalled
);
    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;
    state_t         state_q;
    logic [NCH-1:0] mask_q;
    logic [7:0]     div_sh_q;
    logic [7:0]     div_q;
    logic [3:0]     cnt_q;
    logic [3:0]     idx_q;
    logic           scan_q;
    logic [NCH-1:0] data_q;
    logic           avail_q;
    logic           stalled_q;
    logic [NCH-1:0] sh_q   [NCH];
    logic [NCH-1:0] hold_q [NCH];
    logic [NCH-1:0] word_d [NCH];
    logic [NCH-1:0] src;
    logic           strobe;
    logic           copy;
`ifdef PACKER_TEST_PATTERN_EN
    logic [NCH-1:0] tp_q;
    logic           unused_probe;
    assign unused_probe = ^probe;
    assign src = tp_q;
`else
    assign src = probe;
`endif
    assign sample_data       = data_q;
    assign sample_data_avail = avail_q;
    assign stalled           = stalled_q;
    // Completed words include the sample being taken this cycle, so the copy needs no extra stage.
    always_comb begin
        strobe = (state_q == RUN) && (div_q == 8'd0);
        copy   = strobe && (cnt_q == 4'hF);
        for (int c = 0; c < NCH; c++) word_d[c] = {src[c], sh_q[c][NCH-1:1]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            div_sh_q  <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            scan_q    <= 1'b0;
            data_q    <= '0;
            avail_q   <= 1'b0;
            stalled_q <= 1'b0;
`ifdef PACKER_TEST_PATTERN_EN
            tp_q      <= '0;
`endif
            for (int c = 0; c < NCH; c++) begin
                sh_q[c]   <= '0;
                hold_q[c] <= '0;
            end
        end else begin
            avail_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (acq_enable) begin
                        state_q  <= RUN;
                        mask_q   <= channel_enable;
                        div_sh_q <= clock_divisor;
                        div_q    <= '0;
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        scan_q   <= 1'b0;
`ifdef PACKER_TEST_PATTERN_EN
                        tp_q     <= '0;
`endif
                    end
                end
                RUN: begin
                    if (!acq_enable) begin
                        state_q <= IDLE;
                        scan_q  <= 1'b0;
                    end else begin
                        if (fifo_overflow) begin
                            state_q   <= STALL;
                            stalled_q <= 1'b1;
                        end
                        div_q <= strobe ? div_sh_q : div_q - 8'd1;
                        if (strobe) begin
                            cnt_q <= cnt_q + 4'd1;
`ifdef PACKER_TEST_PATTERN_EN
                            tp_q  <= tp_q + 1'b1;
`endif
                            for (int c = 0; c < NCH; c++) sh_q[c] <= word_d[c];
                        end
                        // Channel 0 is presented straight from the fresh words; the rest come
                        // from the holding buffer, read before any later copy overwrites it.
                        if (copy) begin
                            for (int c = 0; c < NCH; c++) hold_q[c] <= word_d[c];
                            data_q  <= word_d[0];
                            avail_q <= mask_q[0] && !fifo_overflow;
                            idx_q   <= 4'd1;
                            scan_q  <= 1'b1;
                        end else if (scan_q) begin
                            data_q  <= hold_q[idx_q];
                            avail_q <= mask_q[idx_q] && !fifo_overflow;
                            idx_q   <= idx_q + 4'd1;
                            scan_q  <= idx_q != 4'hF;
                        end
                    end
                end
                STALL: begin
                    if (!acq_enable) begin
                        state_q   <= IDLE;
                        stalled_q <= 1'b0;
                        scan_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: vector table, corner sequences and random runs checked against a sample-list model
module tb_sample_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] probe = '0;
    logic        acq = 1'b0;
    logic [7:0]  div = '0;
    logic [15:0] mask = '0;
    logic        ovf = 1'b0;
    logic [15:0] sdata;
    logic        savail;
    logic        stalled;

    sample_packer #(.NCH(16)) dut (
        .clk(clk), .rst_n(rst_n), .probe(probe), .acq_enable(acq),
        .clock_divisor(div), .channel_enable(mask), .fifo_overflow(ovf),
        .sample_data(sdata), .sample_data_avail(savail), .stalled(stalled)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int av_cnt = 0;
    logic [15:0] first_w;
    logic first_seen = 1'b0;

    // Model: 0 idle, 1 run, 2 stall; samples collected as whole 16-bit probe snapshots.
    int m_state = 0;
    int m_r = 0;
    int m_div = 0;
    logic [15:0] m_mask = '0;
    logic [15:0] tp = '0;
    logic [15:0] q[$];
    logic [15:0] exp_w[int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic kill();
        for (int i = cyc + 1; i <= cyc + 20; i++) if (exp_w.exists(i)) exp_w.delete(i);
    endtask

    task automatic model_step();
        logic [15:0] w;
        case (m_state)
            0: if (acq) begin
                m_state = 1; m_div = int'(div); m_mask = mask; m_r = 0; q.delete(); tp = '0;
            end
            1: if (!acq) begin
                m_state = 0; kill();
            end else begin
                if (m_r % (m_div + 1) == 0) begin
`ifdef PACKER_TEST_PATTERN_EN
                    q.push_back(tp);
`else
                    q.push_back(probe);
`endif
                    tp++;
                    if (q.size() == 16) begin
                        for (int k = 0; k < 16; k++) if (m_mask[k]) begin
                            for (int i = 0; i < 16; i++) w[i] = q[i][k];
                            exp_w[cyc + 1 + k] = w;
                        end
                        q.delete();
                    end
                end
                m_r++;
                if (ovf) begin m_state = 2; kill(); end
            end
            default: if (!acq) m_state = 0;
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        chk("avail", 32'(savail), 32'(exp_w.exists(cyc)));
        if (exp_w.exists(cyc)) begin
            chk("data", 32'(sdata), 32'(exp_w[cyc]));
            exp_w.delete(cyc);
        end
        chk("stalled", 32'(stalled), 32'(m_state == 2));
        if (savail) begin
            av_cnt++;
            if (!first_seen) begin first_w = sdata; first_seen = 1'b1; end
        end
        model_step();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic restart();
        acq = 1'b0; ovf = 1'b0;
        run(2);
        av_cnt = 0; first_seen = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  div;
        logic [15:0] mask;
        logic [15:0] probe;
        int          exp_cnt;
        logic [15:0] exp_first;
    } vec_t;
    vec_t vt[6];

    initial begin
`ifdef PACKER_TEST_PATTERN_EN
        vt[0] = '{8'd3,   16'h0005, 16'hFFFB, 2,  16'hAAAA};
        vt[1] = '{8'd0,   16'h0000, 16'h1234, 0,  16'h0000};
        vt[2] = '{8'd1,   16'h8001, 16'h8000, 2,  16'hAAAA};
        vt[3] = '{8'd255, 16'h0010, 16'h0010, 1,  16'h0000};
        vt[4] = '{8'd7,   16'hFFFF, 16'h00FF, 16, 16'hAAAA};
        vt[5] = '{8'd0,   16'h0002, 16'h0002, 1,  16'hCCCC};
`else
        vt[0] = '{8'd3,   16'h0005, 16'hFFFB, 2,  16'hFFFF};
        vt[1] = '{8'd0,   16'h0000, 16'h1234, 0,  16'h0000};
        vt[2] = '{8'd1,   16'h8001, 16'h8000, 2,  16'h0000};
        vt[3] = '{8'd255, 16'h0010, 16'h0010, 1,  16'hFFFF};
        vt[4] = '{8'd7,   16'hFFFF, 16'h00FF, 16, 16'hFFFF};
        vt[5] = '{8'd0,   16'h0002, 16'h0002, 1,  16'hFFFF};
`endif
        // Reset state
        #2;
        @(negedge clk);
        chk("rst_data", 32'(sdata), 32'h0);
        chk("rst_avail", 32'(savail), 32'h0);
        chk("rst_stalled", 32'(stalled), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 100; i++) begin probe = ~probe; ovf = i[3]; tick(); end
        ovf = 1'b0;
        chk("idle_no_avail", 32'(av_cnt), 32'd0);

        // Vector table: one block per entry with constant probe
        for (int v = 0; v < 6; v++) begin
            restart();
            div = vt[v].div; mask = vt[v].mask; probe = vt[v].probe; acq = 1'b1;
            run(16 * (int'(vt[v].div) + 1) + 17);
            chk("vec_count", 32'(av_cnt), 32'(vt[v].exp_cnt));
            if (vt[v].exp_cnt > 0) chk("vec_first", 32'(first_w), 32'(vt[v].exp_first));
        end

        // Divisor 0, alternating probe starting 0x0000 on the first run cycle
        restart();
        div = 8'd0; mask = 16'hFFFF; probe = 16'hFFFF; acq = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin probe = ~probe; tick(); end
        chk("alt_count", 32'(av_cnt), 32'd16);
        chk("alt_word", 32'(first_w), 32'hAAAA);

        // Overflow while channel 5 is presented
        restart();
        div = 8'd0; mask = 16'hFFFF; acq = 1'b1;
        for (int i = 0; i < 100 && av_cnt < 5; i++) begin probe = 16'($urandom); tick(); end
        chk("ovf_reach", 32'(av_cnt), 32'd5);
        ovf = 1'b1;
        tick();
        ovf = 1'b0;
        run(20);
        chk("ovf_words", 32'(av_cnt), 32'd6);
        chk("ovf_sticky", 32'(stalled), 32'd1);
        acq = 1'b0;
        run(2);
        av_cnt = 0;
        acq = 1'b1;
        for (int i = 0; i < 33; i++) begin probe = 16'($urandom); tick(); end
        chk("ovf_resume", 32'(av_cnt), 32'd16);

        // Partial block discarded after 10 strobes
        restart();
        div = 8'd1; mask = 16'hFFFF; acq = 1'b1;
        for (int i = 0; i < 20; i++) begin probe = 16'($urandom); tick(); end
        acq = 1'b0;
        run(3);
        chk("partial_none", 32'(av_cnt), 32'd0);
        acq = 1'b1;
        for (int i = 0; i < 52; i++) begin probe = 16'($urandom); tick(); end
        chk("partial_fresh", 32'(av_cnt), 32'd16);

        // Random runs, with mid-run changes to the shadowed controls
        for (int r = 0; r < 30; r++) begin
            restart();
            div = 8'($urandom_range(0, 5)); mask = 16'($urandom); acq = 1'b1;
            for (int i = 0; i < 150; i++) begin
                probe = 16'($urandom);
                ovf = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 49) == 0) begin div = 8'($urandom); mask = 16'($urandom); end
                acq = ($urandom_range(0, 299) != 0);
                tick();
            end
        end
        ovf = 1'b0; acq = 1'b0;
        run(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
